// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit codes, FSM encoding and sizing helpers.
// Used by the binary-to-BCD converter and the display multiplexer.
package bcd_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_BLANK   = 4'hF;
    localparam logic [3:0]  BCD_NINE    = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // ceil(log2(n)); 0 for n <= 1
    function automatic int clogb2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit cell: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    // correct the digit ahead of the shift
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_dd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero blanking when BIN2BCD_BLANK_EN is defined.
module bin2bcd_dd
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [BIN_WIDTH-1:0]            i_bin,
    output logic [DIGITS*BCD_DIGIT_W-1:0]   o_bcd_data,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_overflow
);

    localparam int S     = DIGITS * BCD_DIGIT_W;
    localparam int CLOG  = clogb2(BIN_WIDTH);
    localparam int CNT_W = (CLOG < 1) ? 1 : CLOG;
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    bcd_state_t          state_q;
    bcd_state_t          state_d;
    logic [BIN_WIDTH-1:0] sh_q;
    logic [S-1:0]        scr_q;
    logic [S-1:0]        scr_adj;
    logic [S-1:0]        res;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                over;

    assign over   = 64'(i_bin) > MAX_VAL;
    assign o_busy = (state_q != IDLE);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [S-1:0] blank(input logic [S-1:0] v);
        logic [S-1:0] r;
        logic         lead;
        r    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0)) begin
                r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    // final value presented at DONE: saturated, blanked or plain
    always_comb begin
        res = scr_q;
        if (ovf_q) begin
            res = {DIGITS{BCD_NINE}};
        end else begin
`ifdef BIN2BCD_BLANK_EN
            res = blank(scr_q);
`else
            res = scr_q;
`endif
        end
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // capture, add-3 then shift, bit counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sh_q  <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (state_q == IDLE && i_start) begin
                sh_q  <= i_bin;
                scr_q <= '0;
                cnt_q <= CNT_W'(BIN_WIDTH - 1);
                ovf_q <= over;
            end else if (state_q == SHIFT) begin
                scr_q <= (scr_adj << 1) | S'(sh_q[BIN_WIDTH-1]);
                sh_q  <= sh_q << 1;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // result register only moves on leaving DONE
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bcd_data <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state_q == DONE) begin
                o_bcd_data <= res;
                o_done     <= 1'b1;
                o_overflow <= ovf_q;
            end
        end
    end

endmodule
